// File: rtl/localizer_pkg.sv
// Shared types and width helpers for the spectral sector localizer.
package localizer_pkg;

    // Frame-level control states.
    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    // Width of the winning-sector index (sectors are channels 1..num_mics-1).
    function automatic int sector_idx_w(input int num_mics);
        return (num_mics > 2) ? $clog2(num_mics - 1) : 1;
    endfunction

    // Width of a full channel index (central mic plus sectors).
    function automatic int chan_idx_w(input int num_mics);
        return (num_mics > 2) ? $clog2(num_mics) : 1;
    endfunction

endpackage

// File: rtl/sector_energy.sv
// Combinational per-channel energy estimate |re| + |im|.
// The most negative sample maps to its true magnitude 2^(SAMPLE_W-1),
// so each magnitude is formed one bit wider than the input.
module sector_energy #(
    parameter int SAMPLE_W = 16
) (
    input  logic [SAMPLE_W-1:0] re,
    input  logic [SAMPLE_W-1:0] im,
    output logic [SAMPLE_W:0]   energy
);

    logic [SAMPLE_W:0] re_ext;
    logic [SAMPLE_W:0] im_ext;
    logic [SAMPLE_W:0] re_mag;
    logic [SAMPLE_W:0] im_mag;

    assign re_ext = {re[SAMPLE_W-1], re};
    assign im_ext = {im[SAMPLE_W-1], im};

    assign re_mag = re_ext[SAMPLE_W] ? (~re_ext + (SAMPLE_W+1)'(1)) : re_ext;
    assign im_mag = im_ext[SAMPLE_W] ? (~im_ext + (SAMPLE_W+1)'(1)) : im_ext;

    // Each magnitude is at most 2^(SAMPLE_W-1), so the sum cannot overflow.
    assign energy = re_mag + im_mag;

endmodule

// File: rtl/spectral_sector_localizer.sv
// Spectral sector localizer: accumulates per-channel band energy over an FFT
// frame, smooths the sector energies across frames and reports the loudest
// sector when it clears a runtime threshold.
module spectral_sector_localizer
    import localizer_pkg::*;
#(
    parameter int NUM_MICS  = 4,
    parameter int SAMPLE_W  = 16,
    parameter int MAX_BINS  = 256,
    localparam int BIN_W    = $clog2(MAX_BINS),
    parameter int ACC_W     = SAMPLE_W + 1 + BIN_W,
    localparam int SEC_W    = sector_idx_w(NUM_MICS)
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [NUM_MICS*2*SAMPLE_W-1:0] fft_data_in,
    input  logic                           fft_valid_in,
    input  logic                           fft_last_in,
    input  logic [BIN_W-1:0]               lower_bound_in,
    input  logic [BIN_W-1:0]               upper_bound_in,
    input  logic [2:0]                     smooth_shift_in,
    input  logic [ACC_W-1:0]               min_mag_in,
    output logic                           localizer_ready_out,
    output logic                           bin_valid_out,
    output logic [SEC_W-1:0]               bin_out,
    output logic [ACC_W-1:0]               magnitude_out,
    output logic                           frame_dropped_out
);

    localparam int NUM_SEC = NUM_MICS - 1;
    localparam int E_W     = SAMPLE_W + 1;
    localparam int CH_W    = chan_idx_w(NUM_MICS);

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(MAX_BINS - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(NUM_SEC - 1);

    state_t            state_q;
    state_t            state_d;

    logic [BIN_W-1:0]  count_q;
    logic [BIN_W-1:0]  lower_q;
    logic [BIN_W-1:0]  upper_q;
    logic              accept;
    logic              contrib;

    logic [E_W-1:0]    energy  [NUM_MICS];
    logic [ACC_W:0]    acc_sum [NUM_MICS];
    // Entry 0 holds the central-mic energy; it is kept for future use and is
    // never a sector candidate.
    logic [ACC_W-1:0]  acc_q   [NUM_MICS];
    logic [ACC_W-1:0]  sm_q    [NUM_SEC];

    logic [SEC_W-1:0]  scan_idx_q;
    logic [CH_W-1:0]   scan_ch;
    logic [ACC_W-1:0]  sec_acc;
    logic [ACC_W-1:0]  sec_sm;
    logic signed [ACC_W:0] diff;
    logic signed [ACC_W:0] step;
    logic signed [ACC_W:0] blend;
    logic [ACC_W-1:0]  sm_next;
    logic [ACC_W-1:0]  max_q;
    logic [SEC_W-1:0]  max_idx_q;

    assign localizer_ready_out = (state_q == ST_ACCUM);
    assign accept  = fft_valid_in && localizer_ready_out;
    // Beat 0 can never contribute, so the stale bounds seen on that beat are harmless.
    assign contrib = accept && (count_q > lower_q) && (count_q < upper_q);

    // One energy unit per channel; channel 0 sits in the LSBs, re below im.
    for (genvar c = 0; c < NUM_MICS; c++) begin : g_chan
        sector_energy #(
            .SAMPLE_W (SAMPLE_W)
        ) u_energy (
            .re     (fft_data_in[c*2*SAMPLE_W +: SAMPLE_W]),
            .im     (fft_data_in[c*2*SAMPLE_W + SAMPLE_W +: SAMPLE_W]),
            .energy (energy[c])
        );

        assign acc_sum[c] = {1'b0, acc_q[c]} + (ACC_W+1)'(energy[c]);
    end

    // Beat counter and per-frame window latch.
    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q <= '0;
            lower_q <= '0;
            upper_q <= '0;
        end else if (accept) begin
            if (count_q == '0) begin
                lower_q <= lower_bound_in;
                upper_q <= upper_bound_in;
            end
            if (fft_last_in) begin
                count_q <= '0;
            end else if (count_q != LAST_BIN) begin
                count_q <= count_q + BIN_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    // NOTE: the default assignment first guarantees state_d is driven on every
    // path, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM:  if (accept && fft_last_in) state_d = ST_SCAN;
            ST_SCAN:   if (scan_idx_q == LAST_SEC) state_d = ST_REPORT;
            ST_REPORT: state_d = ST_ACCUM;
            default:   state_d = ST_ACCUM;
        endcase
    end

    // Saturating energy accumulators, cleared after each report.
    // NOTE: these arrays are reset explicitly because a reset must discard any
    // partial frame; storage without that requirement would be left unreset.
    always_ff @(posedge clk_in) begin
        if (rst_in || state_q == ST_REPORT) begin
            for (int c = 0; c < NUM_MICS; c++) begin
                acc_q[c] <= '0;
            end
        end else if (contrib) begin
            for (int c = 0; c < NUM_MICS; c++) begin
                acc_q[c] <= acc_sum[c][ACC_W] ? ACC_MAX : acc_sum[c][ACC_W-1:0];
            end
        end
    end

    // Smoothing datapath for the sector currently being scanned.
    always_comb begin
        scan_ch = CH_W'(scan_idx_q) + CH_W'(1);
        sec_acc = acc_q[scan_ch];
        sec_sm  = sm_q[scan_idx_q];
        diff    = $signed({1'b0, sec_acc}) - $signed({1'b0, sec_sm});
        step    = diff >>> smooth_shift_in;
        blend   = $signed({1'b0, sec_sm}) + step;
        // The blend always lands between sm and acc, so it fits ACC_W unsigned.
        sm_next = (smooth_shift_in == 3'd0) ? sec_acc : ACC_W'(blend);
    end

    // Sector scan: update one smoothed value per cycle and track the maximum.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            scan_idx_q <= '0;
            max_q      <= '0;
            max_idx_q  <= '0;
            for (int s = 0; s < NUM_SEC; s++) begin
                sm_q[s] <= '0;
            end
        end else if (state_q == ST_SCAN) begin
            sm_q[scan_idx_q] <= sm_next;
            scan_idx_q       <= scan_idx_q + SEC_W'(1);
            // Strict compare keeps the lower index on ties.
            if (scan_idx_q == '0 || sm_next > max_q) begin
                max_q     <= sm_next;
                max_idx_q <= scan_idx_q;
            end
        end else begin
            scan_idx_q <= '0;
        end
    end

    // Result registers and one-cycle status pulses.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bin_valid_out     <= 1'b0;
            bin_out           <= '0;
            magnitude_out     <= '0;
            frame_dropped_out <= 1'b0;
        end else begin
            bin_valid_out     <= 1'b0;
            frame_dropped_out <= fft_valid_in && fft_last_in && !localizer_ready_out;
            if (state_q == ST_REPORT && max_q >= min_mag_in) begin
                bin_valid_out <= 1'b1;
                bin_out       <= max_idx_q;
                magnitude_out <= max_q;
            end
        end
    end

endmodule

// File: tb/tb_spectral_sector_localizer.sv
// Self-checking bench for spectral_sector_localizer: a default-width instance
// plus a narrow-accumulator instance share stimulus; a frame model predicts
// each report and queues it for the output monitors.
module tb_spectral_sector_localizer;

    localparam int NUM_MICS = 4;
    localparam int SAMPLE_W = 16;
    localparam int BIN_W    = 8;
    localparam int ACC_W    = 25;
    localparam int SAT_W    = 20;

    typedef struct {
        int     bin;
        longint mag;
        int     edge_no;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                           rst;
    logic [NUM_MICS*2*SAMPLE_W-1:0] data;
    logic                           valid;
    logic                           last;
    logic [BIN_W-1:0]               lo_b;
    logic [BIN_W-1:0]               hi_b;
    logic [2:0]                     shift;
    logic [ACC_W-1:0]               min_mag;

    logic             ready,   bin_valid,   dropped;
    logic [1:0]       bin;
    logic [ACC_W-1:0] mag;
    logic             ready_s, bin_valid_s, dropped_s;
    logic [1:0]       bin_s;
    logic [SAT_W-1:0] mag_s;

    spectral_sector_localizer dut (
        .clk_in              (clk),
        .rst_in              (rst),
        .fft_data_in         (data),
        .fft_valid_in        (valid),
        .fft_last_in         (last),
        .lower_bound_in      (lo_b),
        .upper_bound_in      (hi_b),
        .smooth_shift_in     (shift),
        .min_mag_in          (min_mag),
        .localizer_ready_out (ready),
        .bin_valid_out       (bin_valid),
        .bin_out             (bin),
        .magnitude_out       (mag),
        .frame_dropped_out   (dropped)
    );

    spectral_sector_localizer #(.ACC_W(SAT_W)) dut_sat (
        .clk_in              (clk),
        .rst_in              (rst),
        .fft_data_in         (data),
        .fft_valid_in        (valid),
        .fft_last_in         (last),
        .lower_bound_in      (lo_b),
        .upper_bound_in      (hi_b),
        .smooth_shift_in     (shift),
        .min_mag_in          (min_mag[SAT_W-1:0]),
        .localizer_ready_out (ready_s),
        .bin_valid_out       (bin_valid_s),
        .bin_out             (bin_s),
        .magnitude_out       (mag_s),
        .frame_dropped_out   (dropped_s)
    );

    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc = 0;
    int     drops_seen = 0;
    longint sums [NUM_MICS];
    longint sm_m [2][NUM_MICS-1];
    longint lim  [2];
    int     cre  [NUM_MICS];
    int     cim  [NUM_MICS];
    bit     rand_data;
    exp_t   q_main[$];
    exp_t   q_sat[$];

    task automatic check(input string tag, input longint got, input longint exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    always @(posedge clk) cyc++;

    // Output monitors: every report pops one prediction.
    always @(negedge clk) begin
        exp_t e;
        if (bin_valid === 1'b1) begin
            if (q_main.size() == 0) begin
                check("unexpected_report", 1, 0);
            end else begin
                e = q_main.pop_front();
                check("report_bin", longint'(bin), e.bin);
                check("report_mag", longint'(mag), e.mag);
                check("report_latency", cyc, e.edge_no);
            end
        end
        if (bin_valid_s === 1'b1) begin
            if (q_sat.size() == 0) begin
                check("unexpected_report_sat", 1, 0);
            end else begin
                e = q_sat.pop_front();
                check("report_bin_sat", longint'(bin_s), e.bin);
                check("report_mag_sat", longint'(mag_s), e.mag);
            end
        end
        if (dropped === 1'b1) drops_seen++;
    end

    // Frame model: saturate, smooth, pick max (lower index on tie), threshold.
    task automatic predict(input int edge_no);
        longint a, best;
        int     bi;
        exp_t   e;
        for (int i = 0; i < 2; i++) begin
            best = -1;
            bi   = 0;
            for (int s = 0; s < NUM_MICS-1; s++) begin
                a = (sums[s+1] > lim[i]) ? lim[i] : sums[s+1];
                if (shift == 3'd0) sm_m[i][s] = a;
                else               sm_m[i][s] = sm_m[i][s] + ((a - sm_m[i][s]) >>> shift);
                if (sm_m[i][s] > best) begin
                    best = sm_m[i][s];
                    bi   = s;
                end
            end
            if (best >= (longint'(min_mag) & lim[i])) begin
                e.bin = bi;
                e.mag = best;
                e.edge_no = edge_no;
                if (i == 0) q_main.push_back(e);
                else        q_sat.push_back(e);
            end
        end
    endtask

    task automatic clear_chan();
        for (int c = 0; c < NUM_MICS; c++) begin
            cre[c] = 0;
            cim[c] = 0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++)
            for (int s = 0; s < NUM_MICS-1; s++) sm_m[i][s] = 0;
    endtask

    task automatic set_beat(output longint e_out [NUM_MICS]);
        int re, im;
        for (int c = 0; c < NUM_MICS; c++) begin
            if (rand_data) begin
                re = int'($urandom_range(0, 65535)) - 32768;
                im = int'($urandom_range(0, 65535)) - 32768;
            end else begin
                re = cre[c];
                im = cim[c];
            end
            data[c*2*SAMPLE_W +: SAMPLE_W]            = SAMPLE_W'(re);
            data[c*2*SAMPLE_W + SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(im);
            e_out[c] = iabs(re) + iabs(im);
        end
    endtask

    // Drives one accepted frame; bounds are scrambled after beat 0.
    task automatic drive_frame(input int n, input int lo, input int hi, input bit expect_rep);
        int     guard = 0;
        int     last_edge = 0;
        longint e [NUM_MICS];
        for (int c = 0; c < NUM_MICS; c++) sums[c] = 0;
        @(negedge clk);
        while (ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_frame", longint'(ready), 1);
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            set_beat(e);
            valid = 1'b1;
            last  = (k == n-1);
            if (k == 0) begin
                lo_b = BIN_W'(lo);
                hi_b = BIN_W'(hi);
            end else begin
                lo_b = '0;
                hi_b = '1;
            end
            if (lo < k && k < hi)
                for (int c = 0; c < NUM_MICS; c++) sums[c] += e[c];
            if (k == n-1) last_edge = cyc + 1;
        end
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
        if (expect_rep) predict(last_edge + NUM_MICS);
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        longint e [NUM_MICS];
        lim[0] = 33554431;
        lim[1] = 1048575;
        model_reset();
        clear_chan();
        rand_data = 1'b0;
        rst = 1'b1; valid = 1'b0; last = 1'b0; data = '0;
        lo_b = '0; hi_b = '0; shift = 3'd0; min_mag = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ready",     longint'(ready), 1);
        check("rst_ready_sat", longint'(ready_s), 1);
        check("rst_valid",     longint'(bin_valid), 0);
        check("rst_bin",       longint'(bin), 0);
        check("rst_mag",       longint'(mag), 0);
        check("rst_dropped",   longint'(dropped), 0);
        check("rst_mag_sat",   longint'(mag_s), 0);
        rst = 1'b0;

        // Single active sector, window 9/225 -> beats 10..224.
        cre[2] = 100;
        drive_frame(256, 9, 225, 1'b1);
        settle();
        check("single_bin", longint'(bin), 1);
        check("single_mag", longint'(mag), 21500);

        // Equal energy on mics 1 and 3, loud central mic ignored.
        clear_chan();
        cre[0] = 30000; cre[1] = 50; cim[1] = -30; cre[3] = -80;
        drive_frame(40, 0, 20, 1'b1);
        settle();
        check("tie_bin", longint'(bin), 0);
        check("tie_mag", longint'(mag), 1520);

        // Random frames through the model.
        rand_data = 1'b1;
        for (int r = 0; r < 3; r++) begin
            drive_frame(int'($urandom_range(20, 256)), int'($urandom_range(0, 100)),
                        int'($urandom_range(0, 255)), 1'b1);
            settle();
        end
        rand_data = 1'b0;
        check("rand_queue_empty", q_main.size(), 0);

        // Smoothing with shift 1 from a cleared state.
        do_reset();
        shift = 3'd1;
        clear_chan();
        cre[1] = 1000;
        drive_frame(4, 0, 2, 1'b1);
        settle();
        check("ema_first", longint'(mag), 500);
        drive_frame(4, 0, 2, 1'b1);
        settle();
        check("ema_second", longint'(mag), 750);

        // Empty window decays the smoothed value; then a frame arrives while busy.
        drive_frame(10, 5, 6, 1'b1);
        clear_chan();
        cre[3] = 30000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_beat(e);
            valid = 1'b1;
            last  = (k == 2);
        end
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
        check("drop_pulse",     longint'(dropped), 1);
        check("drop_pulse_sat", longint'(dropped_s), 1);
        @(negedge clk);
        check("drop_one_cycle", longint'(dropped), 0);
        settle();
        check("decay_bin", longint'(bin), 0);
        check("decay_mag", longint'(mag), 375);

        // Below-threshold frame: no report, outputs hold.
        shift = 3'd0;
        min_mag = ACC_W'(5000);
        clear_chan();
        cre[3] = 4000;
        drive_frame(4, 0, 2, 1'b1);
        settle();
        check("thresh_hold_bin", longint'(bin), 0);
        check("thresh_hold_mag", longint'(mag), 375);

        // Full-scale negative samples: exact sum vs saturated narrow accumulator.
        min_mag = '0;
        for (int c = 0; c < NUM_MICS; c++) cre[c] = -32768;
        drive_frame(256, 0, 255, 1'b1);
        settle();
        check("fullscale_mag", longint'(mag), 8323072);
        check("fullscale_bin", longint'(bin), 0);
        check("sat_mag",       longint'(mag_s), 1048575);

        // Reset while scanning discards the frame.
        clear_chan();
        cre[2] = 500;
        drive_frame(8, 0, 7, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("scan_rst_ready", longint'(ready), 1);
        check("scan_rst_bin",   longint'(bin), 0);
        check("scan_rst_mag",   longint'(mag), 0);
        settle();
        drive_frame(8, 0, 7, 1'b1);
        settle();
        check("post_rst_bin", longint'(bin), 1);
        check("post_rst_mag", longint'(mag), 3000);

        check("main_queue_drained", q_main.size(), 0);
        check("sat_queue_drained",  q_sat.size(), 0);
        check("drop_count",         drops_seen, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spectral_sector_localizer.md
SPECTRAL_SECTOR_LOCALIZER -- requirements
Module: spectral_sector_localizer

Interface
REQ-001 Parameter NUM_MICS, default 4, total microphone channels: channel 0 is the central mic, channels 1..NUM_MICS-1 are sector mics.
REQ-002 Parameter SAMPLE_W, default 16, signed width of each real and imaginary FFT component.
REQ-003 Parameter MAX_BINS, default 256, FFT frame length; BIN_W = $clog2(MAX_BINS).
REQ-004 Parameter ACC_W, default SAMPLE_W+1+BIN_W, width of the energy accumulators.
REQ-005 clk_in  input  1  sole clock; all logic is on its rising edge.
REQ-006 rst_in  input  1  synchronous, active-high reset.
REQ-007 fft_data_in  input  NUM_MICS*2*SAMPLE_W  per-channel {im,re} pairs, channel 0 in the LSBs, re below im.
REQ-008 fft_valid_in  input  1  data beat valid.
REQ-009 fft_last_in  input  1  qualifies the last beat of a frame (only when fft_valid_in=1).
REQ-010 lower_bound_in / upper_bound_in  input  BIN_W each  runtime bin window, exclusive at both ends.
REQ-011 smooth_shift_in  input  3  EMA shift; 0 disables smoothing.
REQ-012 min_mag_in  input  ACC_W  detection threshold.
REQ-013 localizer_ready_out  output  1  high when beats are accepted.
REQ-014 bin_valid_out  output  1  one-cycle pulse that marks a new result.
REQ-015 bin_out  output  $clog2(NUM_MICS-1) (minimum width 1)  winning sector index (0 = mic 1).
REQ-016 magnitude_out  output  ACC_W  smoothed energy of the winning sector.
REQ-017 frame_dropped_out  output  1  one-cycle pulse when a frame is rejected.

Function
REQ-018 Beat counter: counts accepted beats (valid&&ready) from 0; clears on the last beat; saturates at MAX_BINS-1.
REQ-019 Window: lower/upper bounds are latched on beat 0 of each frame. A beat contributes only if lower < count < upper.
REQ-020 Per-channel energy: |re|+|im| zero-extended to SAMPLE_W+1 bits, where |-2^(SAMPLE_W-1)| = 2^(SAMPLE_W-1). Contributing beats add it to acc[c].
REQ-021 Accumulators saturate at all-ones and never wrap.
REQ-022 FSM states:
- ACCUM: ready=1.
- ACCUM -> SCAN on the accepted last beat.
- SCAN: ready=0; one sector per cycle for NUM_MICS-1 cycles.
- SCAN -> REPORT.
- REPORT: one cycle, then -> ACCUM with all acc cleared.
REQ-023 SCAN, per sector s:
- sm[s] <= (smooth_shift_in==0) ? acc[s] : sm[s] + ((acc[s]-sm[s])>>>shift), computed signed at ACC_W+1 bits.
- Track the maximum sm; ties keep the lower index.
REQ-024 REPORT: if max >= min_mag_in, pulse bin_valid_out and update bin_out/magnitude_out; otherwise leave outputs and bin_valid_out unchanged at 0.
REQ-025 Latency: bin_valid_out rises NUM_MICS cycles after the cycle that accepted the last beat.
REQ-026 A frame with upper <= lower+1 contributes nothing and is still scanned, which decays the smoothed values.
REQ-027 A beat presented while ready=0 is ignored. If fft_last_in is among the ignored beats, frame_dropped_out pulses, and the following frame is accumulated normally.
REQ-028 bin_out and magnitude_out hold their values between reports.
REQ-029 Central channel 0 energy is accumulated but is not a sector candidate. It is exported internally for future use and has no output.

Reset
REQ-030 In any state, rst_in forces the following in the next cycle:
- FSM=ACCUM, counter=0, acc and sm cleared.
- bin_out=0, magnitude_out=0, bin_valid_out=0, frame_dropped_out=0, ready=1.
REQ-031 Reset mid-frame or mid-SCAN discards partial results without emitting a report.

Structure
REQ-032 A shared package localizer_pkg holds the FSM state enum and the function giving sector index width.
REQ-033 One sub-module, sector_energy, computes the combinational |re|+|im| for one channel and is instantiated NUM_MICS times.

Verification
REQ-034 Defaults, bounds 9/225, only mic 2 carrying re=100 at every beat -> acc[1] = 215*100 = 21500 (beats 10..224); after the last beat, bin_out=1 and magnitude_out=21500 with smoothing 0.
REQ-035 Mics 1 and 3 carry equal energy -> bin_out=0 (tie rule).
REQ-036 smooth_shift_in=1, two identical frames with energy 1000 on mic 1 -> magnitude_out 500 then 750.
REQ-037 min_mag_in=5000, frame energy 4000 -> no bin_valid_out pulse and outputs unchanged.
REQ-038 Re=-32768 on every beat of a 256-beat frame, bounds 0/255 -> 254 contributing beats (1..254) × 32768 = 8,323,072, which fits ACC_W=25; a saturation check is forced with ACC_W=20 -> magnitude_out=2^20-1.
REQ-039 Reset asserted during SCAN -> no report pulse; the next full frame reports correctly.
